// File: rtl/arm_cond_pkg.sv
// Shared definitions for ARM-style conditional execution: condition codes, SR bit positions
// and the controller state encoding.
package arm_cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // SR layout {Z,C,N,V}
   localparam int unsigned SR_Z = 3;
   localparam int unsigned SR_C = 2;
   localparam int unsigned SR_N = 1;
   localparam int unsigned SR_V = 0;

   localparam int unsigned FLUSH_CNT_W = 3;

   typedef enum logic [0:0] {
      StRun,
      StFlush
   } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit condition passes for a
// given {Z,C,N,V} flag set. Shared by every stage that needs a pass/fail decision.
module cond_eval
   import arm_cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic z;
   logic c;
   logic n;
   logic v;

   assign z = flags[SR_Z];
   assign c = flags[SR_C];
   assign n = flags[SR_N];
   assign v = flags[SR_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution controller: owns SR {Z,C,N,V}, gates ID side effects, stalls on flag
// hazards and holds flush after taken branches. Define FLAG_FORWARD_EN to forward EXE flags.
module cond_exec_ctrl
   import arm_cond_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [3:0] id_cond,
   input  logic       id_branch,
   input  logic       exe_valid,
   input  logic       exe_s,
   input  logic [3:0] exe_flags,
   output logic [3:0] sr,
   output logic       id_exec,
   output logic       id_stall,
   output logic       branch_taken,
   output logic       flush
);

   localparam logic [FLUSH_CNT_W-1:0] FlushInit  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam bit                     MultiFlush = (FLUSH_CYCLES > 1);

   state_e                 state_q;
   state_e                 state_d;
   logic [FLUSH_CNT_W-1:0] cnt_q;
   logic [FLUSH_CNT_W-1:0] cnt_d;
   logic [3:0]             sr_q;
   logic [3:0]             sr_d;

   logic       flag_wr;
   logic       haz;
   logic [3:0] eval_flags;
   logic       cond_pass;

   assign flag_wr = exe_valid & exe_s;

`ifdef FLAG_FORWARD_EN
   // EXE flags are visible to ID in the same cycle, so there is never a reason to wait.
   assign haz        = 1'b0;
   assign eval_flags = flag_wr ? exe_flags : sr_q;
`else
   logic cond_flagless;

   // AL and NV ignore the flags and therefore can never hazard.
   assign cond_flagless = (id_cond == COND_AL) | (id_cond == COND_NV);
   assign haz           = id_valid & flag_wr & ~cond_flagless;
   assign eval_flags    = sr_q;
`endif

   cond_eval u_cond_eval (
      .cond  (id_cond),
      .flags (eval_flags),
      .pass  (cond_pass)
   );

   assign sr_d = flag_wr ? exe_flags : sr_q;
   assign sr   = sr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StRun: begin
            if (branch_taken && MultiFlush) begin
               state_d = StFlush;
               cnt_d   = FlushInit;
            end
         end
         StFlush: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 1) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StRun;
            cnt_d   = '0;
         end
      endcase
   end

   // Decisions are combinational so ID knows in the same cycle whether to commit.
   always_comb begin
      id_exec      = 1'b0;
      id_stall     = 1'b0;
      branch_taken = 1'b0;
      flush        = 1'b0;
      if (!rst) begin
         case (state_q)
            StRun: begin
               id_stall     = haz;
               id_exec      = id_valid & ~haz & cond_pass;
               branch_taken = id_exec & id_branch;
               flush        = branch_taken;
            end
            StFlush: begin
               flush = 1'b1;
            end
            default: begin
               flush = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Self-checking bench for cond_exec_ctrl: a per-cycle reference model plus directed literal checks.
module tb_cond_exec_ctrl;

   localparam int unsigned FC = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [3:0] id_cond;
   logic       id_branch;
   logic       exe_valid;
   logic       exe_s;
   logic [3:0] exe_flags;
   logic [3:0] sr;
   logic       id_exec;
   logic       id_stall;
   logic       branch_taken;
   logic       flush;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   // Model state: committed SR and number of flush cycles still owed after the current one.
   logic [3:0] m_sr    = '0;
   int         m_left  = 0;
   logic [3:0] n_sr    = '0;
   int         n_left  = 0;

   // Bit s of entry c: condition c passes with SR == s (hand-derived).
   logic [15:0] pass_tab [16] = '{
      16'hFF00, 16'h00FF, 16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333, 16'hAAAA, 16'h5555,
      16'h00F0, 16'hFF0F, 16'h9999, 16'h6666, 16'h0099, 16'hFF66, 16'hFFFF, 16'h0000
   };

   cond_exec_ctrl #(
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_cond      (id_cond),
      .id_branch    (id_branch),
      .exe_valid    (exe_valid),
      .exe_s        (exe_s),
      .exe_flags    (exe_flags),
      .sr           (sr),
      .id_exec      (id_exec),
      .id_stall     (id_stall),
      .branch_taken (branch_taken),
      .flush        (flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ARM structure: even codes test a base predicate, odd codes invert it.
   function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
      logic       z;
      logic       cf;
      logic       n;
      logic       v;
      logic [7:0] base;
      z    = f[3];
      cf   = f[2];
      n    = f[1];
      v    = f[0];
      base = {1'b1, ~z & (n == v), (n == v), cf & ~z, v, n, cf, z};
      return base[c[3:1]] ^ c[0];
   endfunction

   always @(negedge clk) begin
      logic       writes;
      logic       stall;
      logic       exec;
      logic       taken;
      logic       fl;
      logic [3:0] flags;
      writes = exe_valid && exe_s;
      stall  = 1'b0;
      exec   = 1'b0;
      taken  = 1'b0;
      fl     = 1'b0;
      n_left = 0;
      if (rst) begin
         n_sr = 4'h0;
      end else begin
         n_sr = writes ? exe_flags : m_sr;
         if (m_left > 0) begin
            fl     = 1'b1;
            n_left = m_left - 1;
         end else begin
`ifdef FLAG_FORWARD_EN
            flags = writes ? exe_flags : m_sr;
`else
            flags = m_sr;
            stall = id_valid && writes && !(id_cond inside {4'hE, 4'hF});
`endif
            exec   = id_valid && !stall && model_pass(id_cond, flags);
            taken  = exec && id_branch;
            fl     = taken;
            n_left = taken ? int'(FC) - 1 : 0;
         end
      end
      if (cmp_on) begin
         check("model sr", sr, m_sr);
         check("model id_exec", {3'b0, id_exec}, {3'b0, exec});
         check("model id_stall", {3'b0, id_stall}, {3'b0, stall});
         check("model branch_taken", {3'b0, branch_taken}, {3'b0, taken});
         check("model flush", {3'b0, flush}, {3'b0, fl});
      end
   end

   always @(posedge clk) begin
      m_sr   <= n_sr;
      m_left <= n_left;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic exp_out(input string tag, input logic ex, input logic st, input logic bt,
                          input logic fl);
      check({tag, " id_exec"}, {3'b0, id_exec}, {3'b0, ex});
      check({tag, " id_stall"}, {3'b0, id_stall}, {3'b0, st});
      check({tag, " branch_taken"}, {3'b0, branch_taken}, {3'b0, bt});
      check({tag, " flush"}, {3'b0, flush}, {3'b0, fl});
   endtask

   initial begin
      rst       = 1'b1;
      id_valid  = 1'b0;
      id_cond   = 4'h0;
      id_branch = 1'b0;
      exe_valid = 1'b0;
      exe_s     = 1'b0;
      exe_flags = 4'h0;
      tick();
      cmp_on = 1'b1;
      look();
      check("reset sr", sr, 4'h0);
      exp_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);

      // Basic EQ/NE against SR == 0
      tick();
      rst      = 1'b0;
      id_valid = 1'b1;
      id_cond  = 4'h0;
      look();
      exp_out("eq sr0", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      id_cond = 4'h1;
      look();
      exp_out("ne sr0", 1'b1, 1'b0, 1'b0, 1'b0);

      // Flag hazard: EXE writes Z while ID asks EQ
      tick();
      id_cond   = 4'h0;
      exe_valid = 1'b1;
      exe_s     = 1'b1;
      exe_flags = 4'b1000;
      look();
      check("haz sr pre", sr, 4'h0);
`ifdef FLAG_FORWARD_EN
      exp_out("haz fwd", 1'b1, 1'b0, 1'b0, 1'b0);
`else
      exp_out("haz stall", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
      tick();
      exe_valid = 1'b0;
      look();
      check("haz sr post", sr, 4'b1000);
      exp_out("haz resolve", 1'b1, 1'b0, 1'b0, 1'b0);

      // AL and NV with a flag write in EXE never stall
      tick();
      exe_valid = 1'b1;
      exe_flags = 4'b0000;
      id_cond   = 4'hE;
      look();
      exp_out("al nostall", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      id_cond = 4'hF;
      look();
      exp_out("nv nostall", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exe_valid = 1'b0;

      // Taken branch: 3-cycle flush, later branches ignored
      id_cond   = 4'hE;
      id_branch = 1'b1;
      look();
      check("br sr", sr, 4'h0);
      exp_out("br c1", 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      look();
      exp_out("br c2", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      look();
      exp_out("br c3", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      id_branch = 1'b0;
      id_cond   = 4'h1;
      look();
      exp_out("br after", 1'b1, 1'b0, 1'b0, 1'b0);

      // Full condition/SR sweep without hazards
      for (int s = 0; s < 16; s++) begin
         tick();
         id_valid  = 1'b0;
         exe_valid = 1'b1;
         exe_s     = 1'b1;
         exe_flags = 4'(s);
         tick();
         exe_valid = 1'b0;
         id_valid  = 1'b1;
         for (int c = 0; c < 16; c++) begin
            id_cond = 4'(c);
            look();
            check("sweep id_exec", {3'b0, id_exec}, {3'b0, pass_tab[c][s]});
            if (c != 15) tick();
         end
      end

      // Reset in the middle of a flush
      tick();
      id_valid  = 1'b0;
      exe_valid = 1'b1;
      exe_flags = 4'b0110;
      tick();
      exe_valid = 1'b0;
      id_valid  = 1'b1;
      id_cond   = 4'hE;
      id_branch = 1'b1;
      look();
      check("rstfl sr", sr, 4'b0110);
      exp_out("rstfl c1", 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      rst       = 1'b1;
      id_branch = 1'b0;
      tick();
      rst       = 1'b0;
      id_branch = 1'b1;
      look();
      check("rstfl sr after", sr, 4'h0);
      exp_out("rstfl run", 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      id_branch = 1'b0;
      tick();
      tick();
      tick();
      look();
      exp_out("final", 1'b1, 1'b0, 1'b0, 1'b0);
      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
